// File: rtl/mc_retire_monitor.sv
// Retirement monitor for the multicycle core: per-instruction cycle/writeback trace, event counters, hang watchdog.
// Retire record and counters update on the fetch edge (1 cycle); a full trace FIFO with no pop drops the record and sets overflow.
module mc_retire_monitor #(
    parameter int                 XLEN        = 32,
    parameter int                 STATE_W     = 4,
    parameter logic [STATE_W-1:0] FETCH_STATE = '0,
    parameter int                 TRACE_DEPTH = 8,
    parameter int                 CNT_W       = 32,
    parameter int                 WDT_LIMIT   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] ctrl_state,
    input  logic               ir_write,
    input  logic               pc_write,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    instr,
    input  logic               reg_write,
    input  logic [XLEN-1:0]    wb_data,
    output logic               retire_valid,
    output logic [7:0]         retire_cycles,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [XLEN-1:0]    trace_pc,
    output logic [XLEN-1:0]    trace_instr,
    output logic [4:0]         trace_rd,
    output logic               trace_wb_valid,
    output logic [XLEN-1:0]    trace_wdata,
    output logic [7:0]         trace_cycles,
    output logic [CNT_W-1:0]   instr_count,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   load_count,
    output logic [CNT_W-1:0]   store_count,
    output logic [CNT_W-1:0]   branch_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow,
    output logic               hang
);
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int WDT_W = $clog2(WDT_LIMIT + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HUNG = 2'd2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WDT_W-1:0] WDT_EXPIRE_AT = WDT_W'(WDT_LIMIT);
    localparam logic [WDT_W-1:0] WDT_ONE       = {{(WDT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic            wb_vld;
        logic [XLEN-1:0] wdata;
        logic [7:0]      cycles;
    } trace_rec_t;

    logic [1:0]       state;
    logic [XLEN-1:0]  cur_pc;
    logic [XLEN-1:0]  wb_dat;
    logic [4:0]       wb_rd;
    logic             wb_seen;
    logic [7:0]       cyc;
    logic [WDT_W-1:0] wdt;
    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;
    trace_rec_t       mem [TRACE_DEPTH];
    trace_rec_t       rec;
    trace_rec_t       head;

    logic fetch_ev, retire, wdt_expire, fifo_full, pop, push, drop;

    // pc_write carries no information the monitor needs beyond ir_write.
    logic unused_pc_write;
    assign unused_pc_write = pc_write;

    assign fetch_ev   = ir_write && (ctrl_state == FETCH_STATE);
    assign retire     = (state == S_RUN) && fetch_ev;
    assign wdt_expire = (state == S_RUN) && !ir_write && (wdt == WDT_EXPIRE_AT);

    assign fifo_full   = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign trace_valid = (wptr != rptr);
    assign pop         = trace_valid && trace_ready;
    assign push        = retire && (!fifo_full || pop);
    assign drop        = retire && fifo_full && !pop;

    // instr still holds the retiring instruction during the fetch cycle.
    always_comb begin
        rec        = '0;
        rec.pc     = cur_pc;
        rec.instr  = instr;
        rec.rd     = wb_rd;
        rec.wb_vld = wb_seen && (wb_rd != 5'd0);
        rec.wdata  = wb_dat;
        rec.cycles = cyc;
    end

    assign head           = trace_valid ? mem[rptr[PTR_W-1:0]] : '0;
    assign trace_pc       = head.pc;
    assign trace_instr    = head.instr;
    assign trace_rd       = head.rd;
    assign trace_wb_valid = head.wb_vld;
    assign trace_wdata    = head.wdata;
    assign trace_cycles   = head.cycles;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wptr[PTR_W-1:0]] <= rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cur_pc        <= '0;
            wb_dat        <= '0;
            wb_rd         <= '0;
            wb_seen       <= 1'b0;
            cyc           <= '0;
            wdt           <= '0;
            wptr          <= '0;
            rptr          <= '0;
            retire_valid  <= 1'b0;
            retire_cycles <= '0;
            instr_count   <= '0;
            cycle_count   <= '0;
            load_count    <= '0;
            store_count   <= '0;
            branch_count  <= '0;
            drop_count    <= '0;
            overflow      <= 1'b0;
            hang          <= 1'b0;
        end else begin
            cycle_count   <= cycle_count + CNT_ONE;
            retire_valid  <= retire;
            retire_cycles <= retire ? cyc : 8'd0;

            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;

            if (retire) begin
                instr_count <= instr_count + CNT_ONE;
                case (instr[6:0])
                    OP_LOAD:   load_count   <= load_count + CNT_ONE;
                    OP_STORE:  store_count  <= store_count + CNT_ONE;
                    OP_BRANCH: branch_count <= branch_count + CNT_ONE;
                    default:   ;
                endcase
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_count + CNT_ONE;
            end

            // Any ir_write kicks the watchdog, even outside FETCH.
            if (ir_write) begin
                wdt <= '0;
            end else if (state == S_RUN) begin
                wdt <= wdt + WDT_ONE;
            end

            case (state)
                S_IDLE: begin
                    if (fetch_ev) begin
                        state   <= S_RUN;
                        cur_pc  <= pc;
                        cyc     <= 8'd1;
                        wb_seen <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (fetch_ev) begin
                        cur_pc  <= pc;
                        cyc     <= 8'd1;
                        wb_seen <= 1'b0;
                    end else begin
                        if (cyc != 8'hFF) cyc <= cyc + 8'd1;
                        if (reg_write) begin
                            wb_rd   <= instr[11:7];
                            wb_dat  <= wb_data;
                            wb_seen <= 1'b1;
                        end
                        if (wdt_expire) begin
                            state <= S_HUNG;
                            hang  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_retire_monitor.sv
// Bench for mc_retire_monitor: drives instruction-level programs and predicts trace records,
// counters and watchdog behaviour from each instruction's length and writebacks.
module tb_mc_retire_monitor;
    localparam int WDT_LIMIT = 16;
    localparam int DEPTH     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ctrl_state;
    logic        ir_write, pc_write, reg_write, trace_ready;
    logic [31:0] pc, instr, wb_data;
    logic        retire_valid, trace_valid, trace_wb_valid, overflow, hang;
    logic [7:0]  retire_cycles, trace_cycles;
    logic [31:0] trace_pc, trace_instr, trace_wdata;
    logic [4:0]  trace_rd;
    logic [31:0] instr_count, cycle_count, load_count, store_count, branch_count, drop_count;

    always #5 clk = ~clk;

    mc_retire_monitor #(
        .XLEN(32), .STATE_W(4), .FETCH_STATE(4'd0), .TRACE_DEPTH(DEPTH), .CNT_W(32), .WDT_LIMIT(WDT_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .ctrl_state(ctrl_state), .ir_write(ir_write), .pc_write(pc_write),
        .pc(pc), .instr(instr), .reg_write(reg_write), .wb_data(wb_data),
        .retire_valid(retire_valid), .retire_cycles(retire_cycles),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_rd(trace_rd),
        .trace_wb_valid(trace_wb_valid), .trace_wdata(trace_wdata), .trace_cycles(trace_cycles),
        .instr_count(instr_count), .cycle_count(cycle_count), .load_count(load_count),
        .store_count(store_count), .branch_count(branch_count), .drop_count(drop_count),
        .overflow(overflow), .hang(hang)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        wbv;
        logic [31:0] wdata;
        logic [7:0]  cyc;
    } rec_t;

    rec_t        q[$];
    rec_t        infl;
    bit          have_infl, infl_wrote, hung;
    int          quiet;
    int unsigned m_cycles, m_instr, m_load, m_store, m_branch, m_drop;
    bit          m_ovf;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic [31:0] ir_reg;
    int          compared = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag);
        chk({tag, "_pc"},    trace_pc,       q[0].pc);
        chk({tag, "_instr"}, trace_instr,    q[0].instr);
        chk({tag, "_rd"},    trace_rd,       q[0].rd);
        chk({tag, "_wbv"},   trace_wb_valid, q[0].wbv);
        chk({tag, "_wdata"}, trace_wdata,    q[0].wdata);
        chk({tag, "_cyc"},   trace_cycles,   q[0].cyc);
    endtask

    // One clock; checks the head entry of any pop happening on this edge.
    task automatic step();
        bit popping;
        popping = 1'b0;
        if (!reset) begin
            chk("trace_valid", trace_valid, q.size() > 0);
            if (trace_ready && q.size() > 0) begin
                popping = 1'b1;
                chk_head("pop");
            end
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            m_cycles++;
            if (popping) q.delete(0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ir_write = 1'b0; pc_write = 1'b0; reg_write = 1'b0; trace_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        q.delete();
        have_infl = 0; infl_wrote = 0; hung = 0; quiet = 0; m_ovf = 0;
        m_cycles = 0; m_instr = 0; m_load = 0; m_store = 0; m_branch = 0; m_drop = 0;
        m_rd = '0; m_wd = '0;
        chk("rst_retire_valid", retire_valid, 0);
        chk("rst_retire_cycles", retire_cycles, 0);
        chk("rst_trace_valid", trace_valid, 0);
        chk("rst_trace_pc", trace_pc, 0);
        chk("rst_trace_wbv", trace_wb_valid, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_hang", hang, 0);
    endtask

    // Fetch cycle of a new instruction: retires the one in flight.
    task automatic fetch(input logic [31:0] pc_v, input logic [31:0] iw);
        bit   exp_ret;
        rec_t r;
        exp_ret    = have_infl && !hung;
        ctrl_state = 4'd0; ir_write = 1'b1; pc_write = 1'b1; pc = pc_v; instr = ir_reg; reg_write = 1'b0;
        r       = infl;
        r.rd    = m_rd;
        r.wbv   = infl_wrote && (m_rd != 5'd0);
        r.wdata = m_wd;
        step();
        if (exp_ret) begin
            m_instr++;
            if (r.instr[6:0] == 7'b0000011) m_load++;
            if (r.instr[6:0] == 7'b0100011) m_store++;
            if (r.instr[6:0] == 7'b1100011) m_branch++;
            if (q.size() < DEPTH) q.push_back(r);
            else begin m_drop++; m_ovf = 1'b1; end
        end
        chk("retire_valid", retire_valid, exp_ret);
        if (exp_ret) chk("retire_cycles", retire_cycles, r.cyc);
        chk("instr_count", instr_count, m_instr);
        chk("cycle_count", cycle_count, m_cycles);
        chk("load_count", load_count, m_load);
        chk("store_count", store_count, m_store);
        chk("branch_count", branch_count, m_branch);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
        chk("hang", hang, hung);
        if (q.size() > 0) chk_head("head");
        if (!hung) begin
            have_infl  = 1'b1;
            infl_wrote = 1'b0;
            infl.pc    = pc_v;
            infl.instr = iw;
            infl.cyc   = 8'd1;
        end
        quiet = 0;
        ir_reg = iw; instr = iw; ir_write = 1'b0; pc_write = 1'b0;
    endtask

    // Remaining ncyc-1 cycles of the instruction; reg_write on cycles wb_a/wb_b,
    // stray non-fetch ir_write every stray_per cycles, optional fixed state.
    task automatic body(input int ncyc, input int wb_a, input int wb_b, input int stray_per, input logic [3:0] hold_st);
        for (int i = 1; i < ncyc; i++) begin
            ctrl_state = (hold_st != 4'd0) ? hold_st : 4'((i - 1) % 9 + 1);
            ir_write   = (stray_per > 0) && (i % stray_per == 0);
            reg_write  = (i == wb_a) || (i == wb_b);
            wb_data    = $urandom;
            if (reg_write && have_infl && !hung) begin
                m_rd = instr[11:7]; m_wd = wb_data; infl_wrote = 1'b1;
            end
            step();
            if (ir_write) quiet = 0;
            else if (have_infl && !hung) quiet++;
            if (have_infl && !hung && quiet >= WDT_LIMIT + 1) hung = 1'b1;
            if (have_infl && !hung && infl.cyc != 8'hFF) infl.cyc = infl.cyc + 8'd1;
            chk("body_retire_valid", retire_valid, 0);
            chk("body_hang", hang, hung);
        end
        ir_write = 1'b0; reg_write = 1'b0;
    endtask

    function automatic logic [31:0] rand_iw();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0:       w[6:0] = 7'b0000011;
            1:       w[6:0] = 7'b0100011;
            2:       w[6:0] = 7'b1100011;
            3:       w[6:0] = 7'b0010011;
            default: w[6:0] = 7'b0110011;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] lw_x5, addi_nop, add_x3;
        int          n;
        lw_x5    = 32'h0040A283;
        addi_nop = 32'h00000013;
        add_x3   = 32'h002081B3;
        ctrl_state = 4'd0; ir_write = 0; pc_write = 0; reg_write = 0; trace_ready = 0;
        pc = '0; instr = '0; wb_data = '0; ir_reg = '0; reset = 1'b1;
        do_reset();

        // LW x5 then ADDI x0 with a writeback to x0
        trace_ready = 1'b1;
        fetch(32'h0, lw_x5);
        body(5, 4, -1, 0, 4'd0);
        fetch(32'h4, addi_nop);
        chk("lw_retire_cycles", retire_cycles, 5);
        chk("lw_rd", trace_rd, 5);
        chk("lw_wbv", trace_wb_valid, 1);
        chk("lw_load_count", load_count, 1);
        chk("lw_instr_count", instr_count, 1);
        body(4, 3, -1, 0, 4'd0);
        fetch(32'h8, addi_nop);
        chk("addi_wbv", trace_wb_valid, 0);
        chk("addi_cycles", trace_cycles, 4);
        chk("addi_load_count", load_count, 1);
        chk("addi_store_count", store_count, 0);
        body(4, 1, 3, 0, 4'd0);

        // cycle saturation, kept alive by stray ir_writes; then 16 quiet cycles (no hang)
        fetch(32'hC, add_x3);
        body(260, 100, -1, 10, 4'd0);
        fetch(32'h10, addi_nop);
        chk("sat_retire_cycles", retire_cycles, 255);
        body(26, 5, -1, 13, 4'd0);
        fetch(32'h14, add_x3);
        body(17, -1, -1, 0, 4'd0);
        fetch(32'h18, addi_nop);
        chk("wdt16_hang", hang, 0);
        chk("wdt16_retire", retire_valid, 1);
        body(3, -1, -1, 0, 4'd0);

        // overflow: 9 retires into an 8-entry FIFO, then full+pop on the 10th
        do_reset();
        for (int k = 0; k < 10; k++) begin
            fetch(32'(4 * k), rand_iw());
            body($urandom_range(3, 6), $urandom_range(0, 2), -1, 0, 4'd0);
        end
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_count, 1);
        chk("ovf_instr", instr_count, 9);
        chk("ovf_head_pc", trace_pc, 32'h0);
        trace_ready = 1'b1;
        fetch(32'h28, rand_iw());
        chk("full_pop_drop", drop_count, 1);
        chk("full_pop_head_pc", trace_pc, 32'h4);
        body(10, -1, -1, 0, 4'd0);
        chk("drained", trace_valid, 0);

        // hang: 17 quiet cycles in state 3
        do_reset();
        fetch(32'h0, add_x3);
        body(18, -1, -1, 0, 4'd3);
        chk("hang_set", hang, 1);
        fetch(32'h4, addi_nop);
        body(3, -1, -1, 0, 4'd0);
        fetch(32'h8, addi_nop);
        chk("hung_no_retire", retire_valid, 0);
        do_reset();

        // reset during MEMREAD of an LW
        fetch(32'h0, lw_x5);
        body(3, -1, -1, 0, 4'd0);
        ctrl_state = 4'd3;
        do_reset();
        fetch(32'h100, add_x3);
        chk("post_rst_no_retire", retire_valid, 0);
        body(4, 3, -1, 0, 4'd0);
        fetch(32'h104, addi_nop);
        chk("post_rst_cycles", retire_cycles, 4);
        chk("post_rst_instr", instr_count, 1);
        body(3, -1, -1, 0, 4'd0);

        // randomized programs with random backpressure
        do_reset();
        for (int k = 0; k < 60; k++) begin
            trace_ready = ($urandom_range(0, 3) != 0);
            n = $urandom_range(3, 9);
            fetch(32'h1000 + 32'(4 * k), rand_iw());
            body(n, $urandom_range(0, n - 1), $urandom_range(0, n - 1),
                 ($urandom_range(0, 4) == 0) ? 3 : 0, 4'd0);
        end
        trace_ready = 1'b1;
        fetch(32'h2000, addi_nop);
        body(12, -1, -1, 0, 4'd0);
        chk("final_drained", trace_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
